// File: rtl/output_drain.sv
`default_nettype none
// ============================================================================
// Module   : output_drain
// Brief    : Write-back stage after the systolic output buffer. Pops up to
//            ARRAYWIDTH rows and writes them to result memory over a
//            valid/ready port at incrementing addresses.
//            Optional macro OUTPUT_DRAIN_RELU_EN zeroes negative lanes.
// Revision : 1.0
// ============================================================================
module output_drain #(
    parameter int ARRAYWIDTH = 8,
    parameter int DATASIZE   = 32,
    parameter int ADDR_W     = 16,
    localparam int CNT_W     = $clog2(ARRAYWIDTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [CNT_W-1:0]               num_rows,
    output logic                           buf_out_en,
    input  logic [ARRAYWIDTH*DATASIZE-1:0] buf_data,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [ARRAYWIDTH*DATASIZE-1:0] wr_data,
    output logic                           busy,
    output logic                           done
);

    localparam int               c_row_w    = ARRAYWIDTH * DATASIZE;
    localparam logic [CNT_W-1:0] c_max_rows = CNT_W'(ARRAYWIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_rows_left;
    logic [ADDR_W-1:0]   r_next_addr;
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [c_row_w-1:0]  r_wr_data;
    logic                r_busy;
    logic                r_done;

    logic                w_slot_free;
    logic                w_pop;
    logic [CNT_W-1:0]    w_rows_clamped;
    logic [c_row_w-1:0]  w_row_proc;

    assign w_rows_clamped = (num_rows > c_max_rows) ? c_max_rows : num_rows;
    assign w_slot_free    = !r_wr_valid || wr_ready;
    assign w_pop          = (r_state == DRAIN) && w_slot_free && (r_rows_left != '0);

    // Per-lane capture path; identical latency with or without ReLU.
    for (genvar i = 0; i < ARRAYWIDTH; i++) begin : g_lane
`ifdef OUTPUT_DRAIN_RELU_EN
        assign w_row_proc[i*DATASIZE +: DATASIZE] =
            buf_data[(i+1)*DATASIZE-1] ? '0 : buf_data[i*DATASIZE +: DATASIZE];
`else
        assign w_row_proc[i*DATASIZE +: DATASIZE] = buf_data[i*DATASIZE +: DATASIZE];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rows_left <= '0;
            r_next_addr <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rows_left <= w_rows_clamped;
                        r_next_addr <= base_addr;
                        r_busy      <= 1'b1;
                        // An empty drain has nothing to pop, so skip straight to completion.
                        r_state     <= (w_rows_clamped == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_slot_free) begin
                        if (r_rows_left != '0) begin
                            r_wr_data   <= w_row_proc;
                            r_wr_addr   <= r_next_addr;
                            r_wr_valid  <= 1'b1;
                            r_next_addr <= r_next_addr + ADDR_W'(1);
                            r_rows_left <= r_rows_left - CNT_W'(1);
                        end else begin
                            r_wr_valid <= 1'b0;
                            r_state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign buf_out_en = w_pop;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_output_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_drain
// Brief    : Directed self-checking bench for output_drain (8 lanes x 32 bit).
// Revision : 1.0
// ============================================================================
module tb_output_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  base_addr;
    logic [3:0]   num_rows;
    logic         buf_out_en;
    logic [255:0] buf_data;
    logic         wr_valid;
    logic         wr_ready;
    logic [15:0]  wr_addr;
    logic [255:0] wr_data;
    logic         busy;
    logic         done;

    output_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .buf_out_en(buf_out_en),
        .buf_data  (buf_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Output buffer model: row k of the stream, every lane non-negative.
    function automatic logic [255:0] mkrow(input int k);
        logic [255:0] r;
        logic [31:0]  kk;
        kk = k;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = {4'h1, kk[11:0], 8'(i), 8'hA5};
        return r;
    endfunction

    logic [255:0] special_row;
    logic [255:0] special_exp;
    bit           use_special = 1'b0;
    int           head = 0;
    int           cyc  = 0;

    assign buf_data = use_special ? special_row : mkrow(head);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (buf_out_en) head <= head + 1;
    end

    // Monitor state, sampled on the falling edge.
    logic [15:0]  wq_addr[$];
    logic [255:0] wq_data[$];
    int           start_cyc = 0;
    int           pops = 0;
    int           first_v_off = -1;
    int           last_w_off = -1;
    int           done_off = -1;
    bit           done_seen = 1'b0;
    bit           busy1 = 1'b0;
    bit           busy_at_done = 1'b0;
    bit           hold_pend = 1'b0;
    logic [15:0]  hold_addr;
    logic [255:0] hold_data;

    always @(negedge clk) begin
        int k;
        k = cyc - start_cyc;
        if (buf_out_en) begin
            pops++;
            check("pop_slot_free", 256'(!wr_valid || wr_ready), 256'd1);
        end
        if (hold_pend) begin
            check("hold_valid", 256'(wr_valid), 256'd1);
            check("hold_addr", 256'(wr_addr), 256'(hold_addr));
            check("hold_data", wr_data, hold_data);
        end
        hold_pend = wr_valid && !wr_ready && !rst;
        hold_addr = wr_addr;
        hold_data = wr_data;
        if (wr_valid && first_v_off < 0) first_v_off = k;
        if (wr_valid && wr_ready) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            last_w_off = k;
        end
        if (k == 1) busy1 = busy;
        if (done && !done_seen) begin
            done_seen    = 1'b1;
            done_off     = k;
            busy_at_done = busy;
        end
    end

    function automatic logic ready_pat(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 3) == 0);
    endfunction

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        pops        = 0;
        first_v_off = -1;
        last_w_off  = -1;
        done_off    = -1;
        done_seen   = 1'b0;
        busy1       = 1'b0;
    endtask

    // mode 0: wr_ready held high; mode 1: wr_ready 1,0,0 repeating.
    task automatic run_drain(input string name, input logic [15:0] base, input logic [3:0] n,
                             input int mode, input bit poke, input bit special);
        int exp_n;
        int exp_done;
        int h0;
        logic [15:0] ea;
        exp_n    = (n > 4'd8) ? 8 : int'(n);
        exp_done = (exp_n == 0) ? 2 : exp_n + 3;
        @(posedge clk); #1;
        clear_mon();
        use_special = special;
        h0          = head;
        start_cyc   = cyc;
        start       = 1'b1;
        base_addr   = base;
        num_rows    = n;
        wr_ready    = ready_pat(mode, 0);
        for (int k = 0; k < 60 && !done_seen; k++) begin
            @(posedge clk); #1;
            start    = poke && (k + 1 == 3);
            if (poke && (k + 1 == 3)) begin
                base_addr = 16'h7777;
                num_rows  = 4'd2;
            end
            wr_ready = ready_pat(mode, k + 1);
        end
        start = 1'b0;
        check({name, "_done_seen"}, 256'(done_seen), 256'd1);
        check({name, "_nwrites"}, 256'(wq_addr.size()), 256'(exp_n));
        check({name, "_pops"}, 256'(pops), 256'(exp_n));
        check({name, "_busy1"}, 256'(busy1), 256'd1);
        check({name, "_busy_at_done"}, 256'(busy_at_done), 256'd0);
        if (mode == 0) begin
            check({name, "_done_off"}, 256'(done_off), 256'(exp_done));
            if (exp_n > 0) begin
                check({name, "_first_valid"}, 256'(first_v_off), 256'd2);
                check({name, "_last_write"}, 256'(last_w_off), 256'(exp_n + 1));
            end else begin
                check({name, "_no_valid"}, 256'(first_v_off), 256'(-1));
            end
        end
        for (int i = 0; i < exp_n && i < wq_addr.size(); i++) begin
            ea = base + 16'(i);
            check({name, "_addr"}, 256'(wq_addr[i]), 256'(ea));
            check({name, "_data"}, wq_data[i], special ? special_exp : mkrow(h0 + i));
        end
        use_special = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        special_row = {{4{32'h0000_1234}}, 32'h0000_0000, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFB};
`ifdef OUTPUT_DRAIN_RELU_EN
        special_exp = {{4{32'h0000_1234}}, 32'h0000_0000, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000};
`else
        special_exp = special_row;
`endif
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 16'h0;
        num_rows  = 4'd0;
        wr_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 256'(wr_valid), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_addr", 256'(wr_addr), 256'd0);
        check("rst_data", wr_data, 256'd0);
        check("rst_pop", 256'(buf_out_en), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_drain("full8", 16'h0100, 4'd8, 0, 1'b0, 1'b0);
        run_drain("stall4", 16'h0200, 4'd4, 1, 1'b1, 1'b0);
        run_drain("zero", 16'h0300, 4'd0, 0, 1'b0, 1'b0);
        run_drain("clamp12", 16'h0400, 4'd12, 0, 1'b0, 1'b0);
        run_drain("wrap", 16'hFFFE, 4'd4, 0, 1'b0, 1'b0);

        // Abort a stalled drain with reset, then confirm a clean restart.
        @(posedge clk); #1;
        clear_mon();
        start_cyc = cyc;
        start     = 1'b1;
        base_addr = 16'h0500;
        num_rows  = 4'd4;
        wr_ready  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_stalled_valid", 256'(wr_valid), 256'd1);
        check("abort_pops", 256'(pops), 256'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 256'(wr_valid), 256'd0);
        check("abort_busy", 256'(busy), 256'd0);
        check("abort_done", 256'(done), 256'd0);
        check("abort_addr", 256'(wr_addr), 256'd0);
        check("abort_data", wr_data, 256'd0);
        check("abort_pop", 256'(buf_out_en), 256'd0);
        check("abort_nwrites", 256'(wq_addr.size()), 256'd0);
        run_drain("restart", 16'h0600, 4'd3, 0, 1'b0, 1'b0);

        run_drain("relu", 16'h0700, 4'd1, 0, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
